// File: rtl/top_rx_decode.sv
// Receive-side decoder: undoes the +1 encoding and buffers decoded bytes in a FWFT FIFO.
module top_rx_decode #(
   parameter int          P_DELAY = 1,
   parameter int unsigned P_DEPTH = 4
) (
   input  logic                           CLK_I,
   input  logic                           RST_X,
   input  logic [7:0]                     DATA_I,
   input  logic                           VALID_I,
   output logic                           READY_O,
   output logic [7:0]                     DATA_O,
   output logic                           WRAP_O,
   output logic                           VALID_O,
   input  logic                           READY_I,
   output logic [$clog2(P_DEPTH):0]       COUNT_O,
   output logic [7:0]                     WRAP_CNT_O
);

   localparam int unsigned AW = $clog2(P_DEPTH);
   localparam int unsigned CW = AW + 1;

   typedef struct packed {
      logic       wrap;
      logic [7:0] data;
   } entry_t;

   // Elaboration-time parameter sanity checks; the delay only affects simulation.
   if (P_DEPTH < 2 || P_DEPTH > 16 || (P_DEPTH & (P_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("top_rx_decode: P_DEPTH must be a power of two in 2..16");
   end
   if (P_DELAY < 0) begin : g_bad_delay
      $error("top_rx_decode: P_DELAY must be non-negative");
   end

   entry_t            mem_q [P_DEPTH];
   entry_t            mem_d [P_DEPTH];
   logic [AW-1:0]     wptr_q, wptr_d;
   logic [AW-1:0]     rptr_q, rptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              ready_q, ready_d;
   logic [7:0]        wrap_cnt_q, wrap_cnt_d;
   logic              push, pop;
   entry_t            in_entry;
   entry_t            head;

   // Next-state for pointers, occupancy, registered ready and wrap counter.
   always_comb begin
      push       = VALID_I && ready_q;
      pop        = (count_q != '0) && READY_I;
      in_entry   = '{wrap: (DATA_I == 8'h00), data: 8'(DATA_I - 8'h01)};
      mem_d      = mem_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      count_d    = count_q;
      wrap_cnt_d = wrap_cnt_q;
      if (push) begin
         mem_d[wptr_q] = in_entry;
         wptr_d        = AW'(wptr_q + AW'(1));
         if (in_entry.wrap && wrap_cnt_q != 8'hFF) begin
            wrap_cnt_d = 8'(wrap_cnt_q + 8'h01);
         end
      end
      if (pop) begin
         rptr_d = AW'(rptr_q + AW'(1));
      end
      if (push && !pop) begin
         count_d = CW'(count_q + CW'(1));
      end else if (pop && !push) begin
         count_d = CW'(count_q - CW'(1));
      end
      ready_d = (count_d < CW'(P_DEPTH));
   end

   // Control state with asynchronous flush on reset.
   always_ff @(posedge CLK_I or negedge RST_X) begin
      if (!RST_X) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         count_q    <= '0;
         ready_q    <= 1'b0;
         wrap_cnt_q <= 8'h00;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         count_q    <= count_d;
         ready_q    <= ready_d;
         wrap_cnt_q <= wrap_cnt_d;
      end
   end

   // Storage array; contents are only observed through the occupancy-qualified head.
   always_ff @(posedge CLK_I) begin
      mem_q <= mem_d;
   end

   // Head presentation, zeroed when the FIFO is empty.
   always_comb begin
      head       = mem_q[rptr_q];
      VALID_O    = (count_q != '0);
      DATA_O     = VALID_O ? head.data : 8'h00;
      WRAP_O     = VALID_O ? head.wrap : 1'b0;
      READY_O    = ready_q;
      COUNT_O    = count_q;
      WRAP_CNT_O = wrap_cnt_q;
   end

endmodule
